// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one backend memory port between fetch and vector data.
// Optional backend timeout with error response when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int MEM_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_mode_i,
    input  logic               if_req_i,
    input  logic [31:0]        if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [31:0]        if_rdata_o,
    output logic               if_err_o,
    input  logic               d_req_i,
    input  logic               d_we_i,
    input  logic [MEM_W/8-1:0] d_be_i,
    input  logic [31:0]        d_addr_i,
    input  logic [31:0]        d_wdata_i,
    output logic               d_gnt_o,
    output logic               d_rvalid_o,
    output logic [31:0]        d_rdata_o,
    output logic               d_err_o,
    output logic               mem_access_o,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    output logic [MEM_W/8-1:0] mem_be_o,
    input  logic [31:0]        mem_rdata_i,
    input  logic               mem_valid_i
);
    localparam int BE_W = MEM_W / 8;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 2..65535");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state, w_next;
    logic              r_owner, r_last;  // 1 = data port, 0 = fetch port
    logic              r_we;
    logic [BE_W-1:0]   r_be;
    logic [31:0]       r_addr, r_wdata;
    logic              r_if_rvalid, r_d_rvalid, r_if_err, r_d_err;
    logic [31:0]       r_if_rdata, r_d_rdata;
    logic              w_gnt_if, w_gnt_d, w_grant, w_done, w_timeout, w_end;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_grant)
            r_cnt <= '0;
        else if (r_state == BUSY && !mem_valid_i)
            r_cnt <= r_cnt + 1'b1;
    end
    assign w_timeout = r_state == BUSY && !mem_valid_i && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    // Fetch wins a tie unless it owned the previous grant.
    always_comb begin
        w_gnt_if = r_state == IDLE && !prog_mode_i && if_req_i && (!d_req_i || r_last);
        w_gnt_d  = r_state == IDLE && !prog_mode_i && d_req_i && (!if_req_i || !r_last);
        w_grant  = w_gnt_if || w_gnt_d;
        w_done   = r_state == BUSY && mem_valid_i;
        w_end    = w_done || w_timeout;
        w_next   = w_grant ? BUSY : w_end ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_err     <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state     <= w_next;
            r_if_rvalid <= w_end && !r_owner;
            r_d_rvalid  <= w_end && r_owner;
            r_if_err    <= w_timeout && !r_owner;
            r_d_err     <= w_timeout && r_owner;
            if (w_end && !r_owner)
                r_if_rdata <= w_done ? mem_rdata_i : '0;
            if (w_end && r_owner)
                r_d_rdata <= w_done ? mem_rdata_i : '0;
            if (w_grant) begin
                r_owner <= w_gnt_d;
                r_last  <= w_gnt_d;
                r_we    <= w_gnt_d && d_we_i;
                r_be    <= w_gnt_d ? d_be_i : '1;
                r_addr  <= w_gnt_d ? d_addr_i : if_addr_i;
                r_wdata <= w_gnt_d ? d_wdata_i : '0;
            end
        end
    end

    assign if_gnt_o     = w_gnt_if;
    assign d_gnt_o      = w_gnt_d;
    assign if_rvalid_o  = r_if_rvalid;
    assign d_rvalid_o   = r_d_rvalid;
    assign if_rdata_o   = r_if_rdata;
    assign d_rdata_o    = r_d_rdata;
    assign if_err_o     = r_if_err;
    assign d_err_o      = r_d_err;
    assign mem_access_o = r_state == BUSY;
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign mem_be_o     = r_be;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latching, response routing, prog mode and reset.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        prog_mode_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o, if_err_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] d_rdata_o;
    logic        mem_access_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_valid_i;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .prog_mode_i(prog_mode_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
        .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .mem_access_o(mem_access_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; prog_mode_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
        mem_rdata_i = '0; mem_valid_i = 1'b0;
        do_reset();
        chk("rst_access", {31'b0, mem_access_o}, 0);
        chk("rst_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 0);
        chk("rst_rdata", if_rdata_o | d_rdata_o, 0);
        chk("rst_mem", mem_addr_o | mem_wdata_o | {28'b0, mem_be_o} | {31'b0, mem_we_o}, 0);
        chk("rst_err", {30'b0, if_err_o, d_err_o}, 0);

        // fetch-only read
        if_req_i = 1'b1; if_addr_i = 32'h40;
        #1;
        chk("f_gnt", {30'b0, if_gnt_o, d_gnt_o}, 2);
        tick();
        if_req_i = 1'b0; if_addr_i = 32'hFFFF_FFFF;
        chk("f_access", {31'b0, mem_access_o}, 1);
        chk("f_addr", mem_addr_o, 32'h40);
        chk("f_we_be", {27'b0, mem_we_o, mem_be_o}, 32'h0F);
        tick();
        chk("f_hold", mem_addr_o, 32'h40);
        mem_valid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        tick();
        mem_valid_i = 1'b0; mem_rdata_i = 32'h0;
        chk("f_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 2);
        chk("f_rdata", if_rdata_o, 32'hDEADBEEF);
        chk("f_idle", {31'b0, mem_access_o}, 0);
        tick();
        chk("f_pulse1", {31'b0, if_rvalid_o}, 0);
        chk("f_rdata_hold", if_rdata_o, 32'hDEADBEEF);

        // tie round-robin after reset: fetch, data, fetch, data
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if_req_i = 1'b1; if_addr_i = 32'h1000 + k;
            d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 4'hF; d_addr_i = 32'h2000 + k;
            #1;
            chk($sformatf("rr_gnt%0d", k), {30'b0, if_gnt_o, d_gnt_o}, (k % 2 == 0) ? 2 : 1);
            chk($sformatf("rr_both%0d", k), {31'b0, if_gnt_o & d_gnt_o}, 0);
            tick();
            chk($sformatf("rr_addr%0d", k), mem_addr_o, (k % 2 == 0) ? 32'h1000 + k : 32'h2000 + k);
            chk($sformatf("rr_busy_gnt%0d", k), {30'b0, if_gnt_o, d_gnt_o}, 0);
            mem_valid_i = 1'b1; mem_rdata_i = 32'hA0 + k;
            tick();
            mem_valid_i = 1'b0;
            chk($sformatf("rr_rv%0d", k), {30'b0, if_rvalid_o, d_rvalid_o}, (k % 2 == 0) ? 2 : 1);
            chk($sformatf("rr_rd%0d", k), (k % 2 == 0) ? if_rdata_o : d_rdata_o, 32'hA0 + k);
        end
        if_req_i = 1'b0; d_req_i = 1'b0;

        // data write: latched values stay stable while inputs change
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_addr_i = 32'h100; d_wdata_i = 32'h1234_5678;
        #1;
        chk("w_gnt", {30'b0, if_gnt_o, d_gnt_o}, 1);
        tick();
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'hC; d_addr_i = 32'h0; d_wdata_i = 32'h0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("w_access%0d", c), {31'b0, mem_access_o}, 1);
            chk($sformatf("w_we_be%0d", c), {27'b0, mem_we_o, mem_be_o}, 32'h13);
            chk($sformatf("w_addr%0d", c), mem_addr_o, 32'h100);
            chk($sformatf("w_wdata%0d", c), mem_wdata_o, 32'h1234_5678);
            if (c == 2) begin
                mem_valid_i = 1'b1; mem_rdata_i = 32'hAAAA_5555;
            end
            tick();
        end
        mem_valid_i = 1'b0;
        chk("w_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 1);
        chk("w_err", {30'b0, if_err_o, d_err_o}, 0);
        tick();
        chk("w_pulse1", {31'b0, d_rvalid_o}, 0);

        // prog mode raised mid-read
        if_req_i = 1'b1; if_addr_i = 32'h200;
        #1;
        chk("p_gnt", {30'b0, if_gnt_o, d_gnt_o}, 2);
        tick();
        if_req_i = 1'b0; prog_mode_i = 1'b1;
        tick();
        mem_valid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        tick();
        mem_valid_i = 1'b0;
        chk("p_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 2);
        chk("p_rdata", if_rdata_o, 32'h1111_2222);
        if_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("p_blocked%0d", c), {29'b0, if_gnt_o, d_gnt_o, mem_access_o}, 0);
            tick();
        end
        prog_mode_i = 1'b0;
        #1;
        chk("p_release", {30'b0, if_gnt_o, d_gnt_o}, 1);
        tick();
        if_req_i = 1'b0; d_req_i = 1'b0;
        chk("p_addr", mem_addr_o, 32'h300);
        mem_valid_i = 1'b1; mem_rdata_i = 32'h3333_4444;
        tick();
        mem_valid_i = 1'b0;
        chk("p_d_rvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 1);

        // reset mid-BUSY, coinciding with a backend completion
        d_req_i = 1'b1; d_addr_i = 32'h400;
        #1;
        chk("r_gnt", {30'b0, if_gnt_o, d_gnt_o}, 1);
        tick();
        d_req_i = 1'b0;
        chk("r_busy", {31'b0, mem_access_o}, 1);
        rst = 1'b1; mem_valid_i = 1'b1; mem_rdata_i = 32'h5555_6666;
        tick();
        rst = 1'b0; mem_valid_i = 1'b0;
        chk("r_access", {31'b0, mem_access_o}, 0);
        chk("r_norvalid", {30'b0, if_rvalid_o, d_rvalid_o}, 0);
        if_req_i = 1'b1; if_addr_i = 32'h500; d_req_i = 1'b1; d_addr_i = 32'h600;
        #1;
        chk("r_tie", {30'b0, if_gnt_o, d_gnt_o}, 2);
        tick();
        if_req_i = 1'b0; d_req_i = 1'b0;
        mem_valid_i = 1'b1; mem_rdata_i = 32'h7777_8888;
        tick();
        mem_valid_i = 1'b0;
        chk("r_after", {30'b0, if_rvalid_o, d_rvalid_o}, 2);
        chk("r_after_rd", if_rdata_o, 32'h7777_8888);

`ifdef ARB_TIMEOUT_EN
        // backend never answers: error response after 8 BUSY cycles
        tick();
        d_req_i = 1'b1; d_addr_i = 32'h700;
        #1;
        chk("t_gnt", {30'b0, if_gnt_o, d_gnt_o}, 1);
        tick();
        d_req_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("t_wait%0d", c), {30'b0, mem_access_o, d_rvalid_o}, 2);
            tick();
        end
        chk("t_rvalid_err", {29'b0, d_rvalid_o, d_err_o, if_rvalid_o}, 6);
        chk("t_rdata", d_rdata_o, 0);
        chk("t_idle", {31'b0, mem_access_o}, 0);
        tick();
        chk("t_pulse1", {30'b0, d_rvalid_o, d_err_o}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single storage-controller memory port between the scalar instruction-fetch port and the vector-unit data port.
- Performs round-robin arbitration and latches the winning request.
- Holds the backend request stable until the backend reports valid, then routes the response back to the owning requester.
- Sits between the core/vproc memory interfaces and storage_controller; gates off new grants while programming mode is active.

Parameters:
- MEM_W, 32: memory bus width in bits; byte-enable width is MEM_W/8.
- TIMEOUT_CYCLES, 1024: backend wait limit in cycles (used only with ARB_TIMEOUT_EN); legal range 2..65535.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- prog_mode_i  in  1  programming mode active; blocks new grants
- if_req_i  in  1  fetch read request
- if_addr_i  in  32  fetch address
- if_gnt_o  out  1  fetch request accepted (combinational, IDLE only)
- if_rvalid_o  out  1  fetch response pulse
- if_rdata_o  out  32  fetch read data
- if_err_o  out  1  fetch response is error
- d_req_i  in  1  data request
- d_we_i  in  1  data write enable
- d_be_i  in  MEM_W/8  data byte enables
- d_addr_i  in  32  data address
- d_wdata_i  in  32  data write data
- d_gnt_o  out  1  data request accepted
- d_rvalid_o  out  1  data response pulse
- d_rdata_o  out  32  data read data
- d_err_o  out  1  data response is error
- mem_access_o  out  1  backend request, held until mem_valid_i
- mem_we_o  out  1  backend write
- mem_addr_o  out  32  backend address
- mem_wdata_o  out  32  backend write data
- mem_be_o  out  MEM_W/8  backend byte enables
- mem_rdata_i  in  32  backend read data
- mem_valid_i  in  1  backend completion pulse

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_owner=DATA, so fetch wins the first tie.
- Reset taken in any state drops any in-flight transaction, issues no rvalid, and drives mem_access_o low on the next cycle.
- Two states: IDLE and BUSY.
- IDLE, grant:
  - If prog_mode_i=0 and at least one req is high, assert the winner's gnt_o combinationally in the same cycle.
  - Register addr/we/be/wdata and owner; go to BUSY next cycle.
  - Fetch requests always register we=0 and be=all ones.
- IDLE, arbitration:
  - Single requester wins.
  - Both requesting: the requester not equal to last_owner wins; last_owner updates on every grant.
- IDLE, other:
  - Only one gnt_o ever high at a time.
  - A requester may drop req before gnt with no effect.
  - mem_valid_i in IDLE is ignored.
- BUSY:
  - mem_access_o=1; mem_* outputs driven from latched registers, stable every cycle.
  - No grants are issued.
  - On mem_valid_i, pulse the owner's rvalid_o for exactly 1 cycle (registered, so the cycle after mem_valid_i).
  - rdata_o carries the value of mem_rdata_i captured at the cycle mem_valid_i is high.
  - For writes rvalid_o still pulses; rdata_o carries the captured value but is not meaningful.
  - Return to IDLE in the same transition; mem_access_o is low for at least 1 cycle between transactions.
- Timing:
  - Minimum latency is gnt to rvalid = 2 + backend latency (cycles from first BUSY cycle to mem_valid_i inclusive).
  - Earliest next grant is the cycle rvalid_o is high.
- prog_mode_i:
  - Rising while BUSY: the in-flight transaction completes normally.
  - While high in IDLE: all gnt_o stay 0; requests wait.
- rdata_o holds its last value between pulses; err_o is 0 unless the optional feature fires.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle without mem_valid_i.
  - When the count reaches TIMEOUT_CYCLES-1 with no mem_valid_i, the next cycle pulses owner rvalid_o and err_o together, with rdata_o=0.
  - mem_access_o drops and state returns to IDLE.
  - mem_valid_i and timeout in the same cycle: mem_valid_i wins, no error.
- Undefined: no counter; err outputs tied 0; BUSY waits indefinitely.

Test Plan:
- Fetch-only: if_req_i=1, if_addr_i=0x0000_0040; backend returns mem_valid_i 1 cycle after mem_access_o rises with rdata 0xDEADBEEF -> if_gnt_o=1 in cycle 0; mem_addr_o=0x40, mem_we_o=0 from cycle 1; if_rvalid_o=1 with if_rdata_o=0xDEADBEEF in cycle 3, for exactly 1 cycle.
- Simultaneous requests after reset, held 4 transactions -> grant order fetch, data, fetch, data; never both gnt_o high.
- Data write: d_we_i=1, d_be_i=4'b0011, d_wdata_i=0x1234_5678, addr 0x100 -> mem_* hold these values every BUSY cycle; d_rvalid_o pulses; if_rvalid_o stays 0.
- prog_mode_i=1 raised during a BUSY read -> that read completes with rvalid; subsequent if_req_i/d_req_i get no gnt until prog_mode_i=0.
- rst=1 for 1 cycle mid-BUSY -> next cycle mem_access_o=0, no rvalid; next grant goes to fetch on tie.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, backend never valid -> after 8 BUSY cycles, d_rvalid_o=1 and d_err_o=1 with d_rdata_o=0; state returns to IDLE.
